instr_loader: RTL

Consumer end of the boot instruction stream. Accepts 32-bit instruction words one per handshake, writes them to consecutive instruction-memory addresses, and detects the end-of-program marker. It then raises `boot_done` and `cpu_run` to hand control to the Control Unit. It sits between the boot word source and the instruction memory write port.

---
 rtl/instr_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// Boot instruction loader: streams 32-bit words into consecutive instruction-memory
// addresses until END_MARKER. Optional checksum word via `LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
   parameter logic [31:0]           END_MARKER = 32'hFFFF_FFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  boot_done,
   output logic                  cpu_run,
   output logic                  load_error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK = 3'd2,
`endif
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  accept;
   logic                  is_marker;
   logic                  full;
   logic                  write_en;

   assign accept    = in_valid & in_ready;
   assign is_marker = (in_data == END_MARKER);
   // word_count reaches 2^ADDR_WIDTH exactly when its top bit sets.
   assign full      = word_count[ADDR_WIDTH];
   assign write_en  = accept && (state == S_LOAD) && !is_marker && !full;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] checksum;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         checksum <= '0;
      end else if (state == S_IDLE && start) begin
         checksum <= '0;
      end else if (write_en) begin
         checksum <= checksum + in_data;
      end
   end
`endif

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned
      // (which would otherwise infer a latch).
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (accept) begin
               if (is_marker) begin
`ifdef LOADER_CHECKSUM_EN
                  state_nxt = S_CHECK;
`else
                  state_nxt = S_DONE;
`endif
               end else if (full) begin
                  state_nxt = S_ERROR;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) state_nxt = (in_data == checksum) ? S_DONE : S_ERROR;
         end
`endif
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      boot_done  = 1'b0;
      cpu_run    = 1'b0;
      load_error = 1'b0;
      case (state)
         S_LOAD:  in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: in_ready = 1'b1;
`endif
         S_DONE: begin
            boot_done = 1'b1;
            cpu_run   = 1'b1;
         end
         S_ERROR: load_error = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // Write port is registered: a word accepted at edge N is written during cycle N+1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr        <= START_ADDR;
         word_count <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_we <= write_en;
         if (state == S_IDLE && start) begin
            ptr        <= START_ADDR;
            word_count <= '0;
         end else if (write_en) begin
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
            mem_addr   <= ptr;
            mem_wdata  <= in_data;
         end
      end
   end

endmodule
